seq_mux_nto1: RTL and testbench
===============================

SEQ_MUX_NTO1 -- requirements
Module: seq_mux_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bit width of each channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have parameter DWELL, default 2, number of cycles each channel is held in scan mode; legal range 1..255.
REQ-004 SHALL have derived localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-005 SHALL have port clock, input, 1, the single clock, rising-edge active.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port data_in, input, CHANNELS*WIDTH, flattened channels; channel k occupies [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sel, input, SEL_W, manual channel select.
REQ-009 SHALL have port mode, input, 1: 0 = manual, 1 = auto-scan.
REQ-010 SHALL have port enable, input, 1, run request, level-sensitive.
REQ-011 SHALL have port data_out, output, WIDTH, registered selected data.
REQ-012 SHALL have port chan_out, output, SEL_W, registered index of the channel driving data_out.
REQ-013 SHALL have port valid, output, 1, high when data_out/chan_out reflect a sample taken on the previous edge.
REQ-014 SHALL have port wrap, output, 1, one-cycle pulse on scan wrap-around.

Function
REQ-015 SHALL implement an FSM with states IDLE, MANUAL, SCAN; all outputs SHALL be registered.
REQ-016 In IDLE, with enable=1, the FSM SHALL go to MANUAL if mode=0, or to SCAN if mode=1, on the next edge; with enable=0 it SHALL remain in IDLE.
REQ-017 In MANUAL with enable=1, each edge SHALL load data_out <= channel sel, chan_out <= sel, valid <= 1; latency is 1 cycle from sel/data_in to data_out.
REQ-018 In MANUAL, if sel >= CHANNELS, data_out and chan_out SHALL hold their previous values and valid SHALL drop to 0 for that cycle.
REQ-019 On entry to SCAN, the channel index and dwell counter SHALL both be 0.
REQ-020 In SCAN, each edge SHALL load data_out <= channel index, chan_out <= index, valid <= 1.
REQ-021 In SCAN, the dwell counter SHALL count 0..DWELL-1; on the edge where it equals DWELL-1, the index SHALL advance by 1 and the counter SHALL return to 0.
REQ-022 In SCAN, an advance from index CHANNELS-1 SHALL wrap the index to 0 and assert wrap for exactly the following cycle; wrap SHALL be 0 at all other times.
REQ-023 On a mode change while enable=1, the FSM SHALL switch between MANUAL and SCAN on the next edge; entry into SCAN follows REQ-019.
REQ-024 On enable=0 in MANUAL or SCAN, the FSM SHALL return to IDLE on the next edge, valid SHALL drop to 0, and data_out/chan_out SHALL hold their last values.
REQ-025 On re-enable after IDLE, SCAN SHALL restart at channel 0; scan position SHALL NOT be retained.
REQ-026 data_in changes SHALL only affect outputs at clock edges; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 While reset=1, the FSM SHALL be IDLE and data_out, chan_out, valid, wrap, the index and the dwell counter SHALL all be 0, asynchronously, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL take effect immediately; after release, operation SHALL resume only via REQ-016 on the first edge with enable=1.

Verification
REQ-029 Reset check: WIDTH=4, CHANNELS=4; assert reset between edges while in SCAN -> all outputs 0 before the next edge; after release with enable=0 -> outputs stay 0.
REQ-030 Manual check: data_in=16'hD3A5, mode=0, enable=1, sel=2 -> one edge later data_out=4'h3, chan_out=2, valid=1; sel=3 -> data_out=4'hD on the next edge.
REQ-031 Scan check: DWELL=2, data_in=16'h4321, mode=1, enable=1 -> data_out sequence 1,1,2,2,3,3,4,4,1; wrap=1 only in the cycle data_out first returns to 1.
REQ-032 Illegal select: CHANNELS=3, WIDTH=4, sel=3 in MANUAL -> data_out/chan_out unchanged, valid=0; sel=1 next -> valid=1 with channel 1 data.
REQ-033 Pause/restart: in SCAN at index 2, drop enable -> next cycle valid=0 with outputs held; raise enable -> first sample is channel 0, dwell restarts.
REQ-034 Mode switch: in SCAN at index 1, set mode=0 with sel=3 -> next edge chan_out=3 in MANUAL; set mode=1 -> next edge chan_out=0.

Source files
------------

// File: rtl/seq_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module      : seq_mux_nto1
// Description : N-to-1 sequencing multiplexer with manual channel select and
//               a dwell-timed auto-scan mode. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mux_nto1 #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      enable,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      valid,
  output logic                      wrap
);

  // Dwell counter only needs to reach DWELL-1; keep it at least one bit wide.
  localparam int c_CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  // Channel lookup table is padded to a power of two so any sel value
  // indexes a real entry; the padding entries are never selected.
  localparam int c_SLOTS = 1 << SEL_W;

  localparam logic [SEL_W-1:0]   c_IDX_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]     c_CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_MANUAL = 2'd1;
  localparam logic [1:0] c_SCAN   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic [SEL_W-1:0]   r_idx;
  logic [c_CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic [WIDTH-1:0]   r_data_out;
  logic [SEL_W-1:0]   r_chan_out;
  logic               r_valid;
  logic               r_wrap;

  logic [WIDTH-1:0]   w_data_nxt;
  logic [SEL_W-1:0]   w_chan_nxt;
  logic               w_valid_nxt;
  logic               w_wrap_nxt;

  logic [WIDTH-1:0]   w_chan [c_SLOTS];
  logic               w_sel_ok;
  logic               w_dwell_done;

  // Unpack the flattened channel bus into an indexable table.
  generate
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_chan
      if (k < CHANNELS) begin : g_real
        assign w_chan[k] = data_in[k*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_chan[k] = '0;
      end
    end
  endgenerate

  // Manual select is only honoured for indices that name a real channel.
  assign w_sel_ok     = ({1'b0, sel} < c_CH_LIMIT);
  assign w_dwell_done = (r_cnt == c_CNT_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enable gates operation, mode picks manual or scan; a mode
  // flip while enabled moves directly between the two running states.
  always_comb begin
    w_state_nxt = c_IDLE;
    case (r_state)
      c_IDLE, c_MANUAL, c_SCAN: begin
        if (!enable) begin
          w_state_nxt = c_IDLE;
        end else if (mode) begin
          w_state_nxt = c_SCAN;
        end else begin
          w_state_nxt = c_MANUAL;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Scan position: (r_idx, r_cnt) always describes the sample currently on
  // data_out. Entering scan starts at (0,0); staying in scan steps the dwell
  // counter and advances the channel once the dwell is used up. Leaving scan
  // discards the position so a later scan always restarts at channel 0.
  always_comb begin
    w_idx_nxt  = '0;
    w_cnt_nxt  = '0;
    w_wrap_nxt = 1'b0;
    if (w_state_nxt == c_SCAN && r_state == c_SCAN) begin
      if (w_dwell_done) begin
        w_cnt_nxt = '0;
        if (r_idx == c_IDX_LAST) begin
          w_idx_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + SEL_W'(1);
        end
      end else begin
        w_idx_nxt = r_idx;
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
      end
    end
  end

  // Output decode: values to be captured at the coming edge, chosen by the
  // state being entered so a mode switch shows the new mode's sample at once.
  always_comb begin
    w_data_nxt  = r_data_out;
    w_chan_nxt  = r_chan_out;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      c_MANUAL: begin
        if (w_sel_ok) begin
          w_data_nxt  = w_chan[sel];
          w_chan_nxt  = sel;
          w_valid_nxt = 1'b1;
        end
      end
      c_SCAN: begin
        w_data_nxt  = w_chan[w_idx_nxt];
        w_chan_nxt  = w_idx_nxt;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Scan position registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output registers; nothing reaches a port without passing through here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
      r_chan_out <= '0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_data_out <= w_data_nxt;
      r_chan_out <= w_chan_nxt;
      r_valid    <= w_valid_nxt;
      r_wrap     <= w_wrap_nxt;
    end
  end

  assign data_out = r_data_out;
  assign chan_out = r_chan_out;
  assign valid    = r_valid;
  assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seq_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mux_nto1
// Description : Self-checking bench for seq_mux_nto1 (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_mux_nto1;

  localparam int W   = 4;
  localparam int CA  = 4;
  localparam int DA  = 2;
  localparam int CB  = 3;
  localparam int DB  = 3;
  localparam int SWA = 2;
  localparam int SWB = 2;

  logic clk = 1'b0;
  logic rst;

  logic [CA*W-1:0] din_a;
  logic [SWA-1:0]  sel_a;
  logic            mode_a, en_a;
  logic [W-1:0]    dout_a;
  logic [SWA-1:0]  chan_a;
  logic            valid_a, wrap_a;

  logic [CB*W-1:0] din_b;
  logic [SWB-1:0]  sel_b;
  logic            mode_b, en_b;
  logic [W-1:0]    dout_b;
  logic [SWB-1:0]  chan_b;
  logic            valid_b, wrap_b;

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per DUT
  int           m_k    [2];
  int           m_run  [2];   // 0 idle, 1 manual, 2 scan
  logic [W-1:0] m_data [2];
  logic [1:0]   m_chan [2];
  logic         m_valid[2];
  logic         m_wrap [2];

  seq_mux_nto1 #(.WIDTH(W), .CHANNELS(CA), .DWELL(DA)) dut_a (
    .clock(clk), .reset(rst), .data_in(din_a), .sel(sel_a), .mode(mode_a),
    .enable(en_a), .data_out(dout_a), .chan_out(chan_a), .valid(valid_a),
    .wrap(wrap_a)
  );

  seq_mux_nto1 #(.WIDTH(W), .CHANNELS(CB), .DWELL(DB)) dut_b (
    .clock(clk), .reset(rst), .data_in(din_b), .sel(sel_b), .mode(mode_b),
    .enable(en_b), .data_out(dout_b), .chan_out(chan_b), .valid(valid_b),
    .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_k[i] = 0; m_run[i] = 0; m_data[i] = '0; m_chan[i] = '0;
      m_valid[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endfunction

  // Scan position is derived from the sample count k since scan entry:
  // channel = (k / dwell) mod channels, wrap flagged when a full sweep of
  // channels*dwell samples has just completed.
  function automatic void model_step(int i, bit en, bit md, int sl,
                                     logic [63:0] din, int ch, int dw);
    int idx;
    if (!en) begin
      m_run[i] = 0; m_valid[i] = 1'b0; m_wrap[i] = 1'b0;
    end else if (md) begin
      if (m_run[i] != 2) m_k[i] = 0;
      else m_k[i] = m_k[i] + 1;
      m_run[i]   = 2;
      idx        = (m_k[i] / dw) % ch;
      m_data[i]  = W'(din >> (idx * W));
      m_chan[i]  = 2'(idx);
      m_valid[i] = 1'b1;
      m_wrap[i]  = (m_k[i] > 0) && (m_k[i] % (dw * ch) == 0);
    end else begin
      m_run[i]  = 1;
      m_wrap[i] = 1'b0;
      if (sl < ch) begin
        m_data[i]  = W'(din >> (sl * W));
        m_chan[i]  = 2'(sl);
        m_valid[i] = 1'b1;
      end else begin
        m_valid[i] = 1'b0;
      end
    end
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_a = 1'b0; mode_a = 1'b0; sel_a = '0; din_a = '0;
    en_b = 1'b0; mode_b = 1'b0; sel_b = '0; din_b = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en_a = 1'b0; mode_a = 1'b0; sel_a = '0; din_a = '0;
    en_b = 1'b0; mode_b = 1'b0; sel_b = '0; din_b = '0;
    rst = 1'b1;
    edge_step();
    checks++;
    if (dout_a !== 4'h0 || chan_a !== 2'd0 || valid_a !== 1'b0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got data=%h chan=%0d valid=%b wrap=%b, want all 0",
               dout_a, chan_a, valid_a, wrap_a);
    end
    rst = 1'b0;
    din_a = 16'h4321; mode_a = 1'b1; en_a = 1'b1;
    repeat (3) edge_step();
    checks++;
    if (dout_a !== 4'h2 || chan_a !== 2'd1 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_prescan: got data=%h chan=%0d valid=%b, want data=2 chan=1 valid=1",
               dout_a, chan_a, valid_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout_a !== 4'h0 || chan_a !== 2'd0 || valid_a !== 1'b0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got data=%h chan=%0d valid=%b wrap=%b, want all 0",
               dout_a, chan_a, valid_a, wrap_a);
    end
    en_a = 1'b0;
    rst  = 1'b0;
    repeat (3) edge_step();
    checks++;
    if (dout_a !== 4'h0 || chan_a !== 2'd0 || valid_a !== 1'b0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got data=%h chan=%0d valid=%b wrap=%b, want all 0",
               dout_a, chan_a, valid_a, wrap_a);
    end
  endtask

  task automatic test_manual();
    do_reset();
    din_a = 16'hD3A5; mode_a = 1'b0; en_a = 1'b1; sel_a = 2'd2;
    edge_step();
    checks++;
    if (dout_a !== 4'h3 || chan_a !== 2'd2 || valid_a !== 1'b1 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL manual_sel2: got data=%h chan=%0d valid=%b wrap=%b, want 3/2/1/0",
               dout_a, chan_a, valid_a, wrap_a);
    end
    sel_a = 2'd3;
    edge_step();
    checks++;
    if (dout_a !== 4'hD || chan_a !== 2'd3 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL manual_sel3: got data=%h chan=%0d valid=%b, want D/3/1",
               dout_a, chan_a, valid_a);
    end
  endtask

  task automatic test_scan();
    int seq[10] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1};
    do_reset();
    din_a = 16'h4321; mode_a = 1'b1; en_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge_step();
      checks++;
      if (dout_a !== W'(seq[i]) || chan_a !== 2'(seq[i] - 1) || valid_a !== 1'b1 ||
          wrap_a !== (i == 8)) begin
        errors++;
        $display("FAIL scan_seq[%0d]: got data=%h chan=%0d valid=%b wrap=%b, want data=%0d chan=%0d valid=1 wrap=%b",
                 i, dout_a, chan_a, valid_a, wrap_a, seq[i], seq[i] - 1, (i == 8));
      end
    end
  endtask

  task automatic test_illegal_sel();
    do_reset();
    din_b = 12'h7B2; mode_b = 1'b0; en_b = 1'b1; sel_b = 2'd2;
    edge_step();
    checks++;
    if (dout_b !== 4'h7 || chan_b !== 2'd2 || valid_b !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pre: got data=%h chan=%0d valid=%b, want 7/2/1",
               dout_b, chan_b, valid_b);
    end
    sel_b = 2'd3;
    edge_step();
    checks++;
    if (dout_b !== 4'h7 || chan_b !== 2'd2 || valid_b !== 1'b0) begin
      errors++;
      $display("FAIL illegal_sel3: got data=%h chan=%0d valid=%b, want 7/2/0",
               dout_b, chan_b, valid_b);
    end
    sel_b = 2'd1;
    edge_step();
    checks++;
    if (dout_b !== 4'hB || chan_b !== 2'd1 || valid_b !== 1'b1) begin
      errors++;
      $display("FAIL illegal_recover: got data=%h chan=%0d valid=%b, want B/1/1",
               dout_b, chan_b, valid_b);
    end
  endtask

  task automatic test_pause_restart();
    do_reset();
    din_a = 16'h4321; mode_a = 1'b1; en_a = 1'b1;
    repeat (5) edge_step();
    checks++;
    if (chan_a !== 2'd2 || dout_a !== 4'h3 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL pause_at2: got data=%h chan=%0d valid=%b, want 3/2/1",
               dout_a, chan_a, valid_a);
    end
    en_a = 1'b0;
    edge_step();
    checks++;
    if (chan_a !== 2'd2 || dout_a !== 4'h3 || valid_a !== 1'b0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: got data=%h chan=%0d valid=%b wrap=%b, want 3/2/0/0",
               dout_a, chan_a, valid_a, wrap_a);
    end
    en_a = 1'b1;
    edge_step();
    checks++;
    if (chan_a !== 2'd0 || dout_a !== 4'h1 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL restart_first: got data=%h chan=%0d valid=%b, want 1/0/1",
               dout_a, chan_a, valid_a);
    end
    edge_step();
    edge_step();
    checks++;
    if (chan_a !== 2'd1 || dout_a !== 4'h2) begin
      errors++;
      $display("FAIL restart_dwell: got data=%h chan=%0d, want 2/1", dout_a, chan_a);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    din_a = 16'h4321; mode_a = 1'b1; en_a = 1'b1; sel_a = 2'd3;
    repeat (3) edge_step();
    checks++;
    if (chan_a !== 2'd1) begin
      errors++;
      $display("FAIL switch_at1: got chan=%0d, want 1", chan_a);
    end
    mode_a = 1'b0;
    edge_step();
    checks++;
    if (chan_a !== 2'd3 || dout_a !== 4'h4 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL switch_to_manual: got data=%h chan=%0d valid=%b, want 4/3/1",
               dout_a, chan_a, valid_a);
    end
    mode_a = 1'b1;
    edge_step();
    checks++;
    if (chan_a !== 2'd0 || dout_a !== 4'h1 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL switch_to_scan: got data=%h chan=%0d valid=%b, want 1/0/1",
               dout_a, chan_a, valid_a);
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dout_a !== m_data[0] || chan_a !== m_chan[0] || valid_a !== m_valid[0] ||
            wrap_a !== m_wrap[0] || dout_b !== m_data[1] || chan_b !== m_chan[1] ||
            valid_b !== m_valid[1] || wrap_b !== m_wrap[1]) begin
          errors++;
          $display("FAIL rand_reset cyc=%0d: got a=%h/%0d/%b/%b b=%h/%0d/%b/%b, want all 0",
                   n, dout_a, chan_a, valid_a, wrap_a, dout_b, chan_b, valid_b, wrap_b);
        end
        rst = 1'b0;
      end
      din_a  = 16'($urandom);
      din_b  = 12'($urandom);
      sel_a  = 2'($urandom);
      sel_b  = 2'($urandom);
      en_a   = ($urandom_range(0, 7) != 0);
      en_b   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 9) == 0) mode_b = ~mode_b;
      model_step(0, en_a, mode_a, int'(sel_a), 64'(din_a), CA, DA);
      model_step(1, en_b, mode_b, int'(sel_b), 64'(din_b), CB, DB);
      edge_step();
      checks++;
      if (dout_a !== m_data[0] || chan_a !== m_chan[0] || valid_a !== m_valid[0] ||
          wrap_a !== m_wrap[0]) begin
        errors++;
        $display("FAIL rand_a cyc=%0d: got data=%h chan=%0d valid=%b wrap=%b, want data=%h chan=%0d valid=%b wrap=%b",
                 n, dout_a, chan_a, valid_a, wrap_a, m_data[0], m_chan[0], m_valid[0], m_wrap[0]);
      end
      checks++;
      if (dout_b !== m_data[1] || chan_b !== m_chan[1] || valid_b !== m_valid[1] ||
          wrap_b !== m_wrap[1]) begin
        errors++;
        $display("FAIL rand_b cyc=%0d: got data=%h chan=%0d valid=%b wrap=%b, want data=%h chan=%0d valid=%b wrap=%b",
                 n, dout_b, chan_b, valid_b, wrap_b, m_data[1], m_chan[1], m_valid[1], m_wrap[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_manual();
    test_scan();
    test_illegal_sel();
    test_pause_restart();
    test_mode_switch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
